// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial adder.
package add_seq_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_8bit.sv
// Combinational slice adder: {cout, sum} = a + b + cin.
module adder_8bit
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  // Full slice addition with carry-in and carry-out
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/serial_add_seq.sv
// Multi-cycle adder: one shared 8-bit adder walks the operands slice by slice,
// LSB slice first, with a valid/ready handshake on both request and result.
module serial_add_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] A_i,
  input  logic [DATA_W-1:0] B_i,
  input  logic              cin_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] SUM_o,
  output logic              cout_o,
  output logic              ovf_o,
  output logic              busy_o
);

  localparam int unsigned NS    = DATA_W / SLICE_W;
  localparam int unsigned CNT_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned MSB   = DATA_W - 1;

  state_t              state;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                carry_q;
  logic [CNT_W-1:0]    k_q;
  logic [SLICE_W-1:0]  a_slice;
  logic [SLICE_W-1:0]  b_slice;
  logic [SLICE_W-1:0]  add_sum;
  logic                add_cout;
  logic                last_slice;

  // Select the operand slices addressed by the slice counter
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (k_q == CNT_W'(i)) begin
        a_slice = a_q[i*SLICE_W +: SLICE_W];
        b_slice = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  assign last_slice = (k_q == CNT_W'(NS - 1));

  adder_8bit u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Sequencer: accept, iterate slices, then hold the result until consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      SUM_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_q     <= A_i;
            b_q     <= B_i;
            carry_q <= cin_i;
            k_q     <= '0;
            SUM_o   <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          for (int unsigned i = 0; i < NS; i++) begin
            if (k_q == CNT_W'(i)) begin
              SUM_o[i*SLICE_W +: SLICE_W] <= add_sum;
            end
          end
          carry_q <= add_cout;
          k_q     <= k_q + CNT_W'(1);
          if (last_slice) begin
            // The final slice's adder MSB is the result MSB, so overflow can
            // be resolved on this same edge without waiting for SUM_o.
            cout_o  <= add_cout;
            ovf_o   <= (a_q[MSB] == b_q[MSB]) && (add_sum[SLICE_W-1] != a_q[MSB]);
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand width in bits; multiple of 8, minimum 16.
REQ-002 SHALL have ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- A_i  in  DATA_W  operand A.
- B_i  in  DATA_W  operand B.
- cin_i  in  1  carry-in.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- SUM_o  out  DATA_W  sum.
- cout_o  out  1  carry-out of the MSB.
- ovf_o  out  1  two's-complement overflow.
- busy_o  out  1  high in CALC or DONE.

Function
REQ-003 SHALL compute {cout_o, SUM_o} = A + B + cin modulo 2^(DATA_W+1), using one shared 8-bit adder over NS = DATA_W/8 cycles.
REQ-004 SHALL implement FSM states IDLE, CALC and DONE.
- IDLE: ready_o=1, valid_o=0.
- CALC: ready_o=0, valid_o=0.
- DONE: ready_o=0, valid_o=1.
REQ-005 SHALL accept a request on a rising edge with valid_i=1 in IDLE.
- Capture A_i, B_i and cin_i into internal registers.
- Clear the slice counter to 0.
- Clear SUM_o to 0.
- Go to CALC.
REQ-006 SHALL, on each CALC cycle with slice counter k:
- Drive A[8k+7:8k], B[8k+7:8k] and the carry register into the 8-bit adder.
- Register the adder sum into SUM_o[8k+7:8k].
- Register the adder carry-out into the carry register.
- Increment k.
REQ-007 SHALL go from CALC to DONE on the edge that processes slice NS-1, registering cout_o from that slice's carry-out.
REQ-008 SHALL set ovf_o = (A[MSB]==B[MSB]) && (SUM[MSB]!=A[MSB]), registered on the same edge as cout_o.
REQ-009 SHALL assert valid_o exactly NS cycles after the accepting edge; 4 for DATA_W=32.
REQ-010 SHALL hold valid_o, SUM_o, cout_o and ovf_o stable in DONE until a rising edge with ready_i=1; that edge returns the FSM to IDLE.
REQ-011 SHALL ignore valid_i in CALC and DONE; no request is queued or dropped-with-side-effect.
REQ-012 SHALL keep SUM_o, cout_o and ovf_o at their last values in IDLE.
REQ-013 SHALL NOT let operand input changes after acceptance affect the result.
REQ-014 SHALL handle wrap-around: all-ones + 1 gives SUM_o=0, cout_o=1.
REQ-015 SHALL support back-to-back operations with minimum spacing NS+2 cycles from accept to next accept (DONE handshake, then IDLE).

Reset
REQ-016 SHALL, while rst_i=1 regardless of clock, force:
- state=IDLE, slice counter=0, carry register=0, operand registers=0.
- SUM_o=0, cout_o=0, ovf_o=0, valid_o=0, busy_o=0.
- ready_o=1.
REQ-017 SHALL abandon any in-flight operation on reset mid-CALC or mid-DONE, with no result presented after release.

Structure
REQ-018 SHALL place the state enum typedef and localparam SLICE_W=8 in shared package add_seq_pkg.
REQ-019 SHALL instantiate exactly one adder_8bit as the datapath sub-module; all sequencing, muxing and registers live in serial_add_seq.
REQ-020 SHALL size the slice counter $clog2(NS) bits.

Verification
REQ-021 Basic: A=0x0000_0001, B=0x0000_0002, cin=0 -> valid_o 4 cycles after accept, SUM_o=0x0000_0003, cout_o=0, ovf_o=0.
REQ-022 Ripple across slices: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> SUM_o=0x0000_0000, cout_o=1, ovf_o=0.
REQ-023 Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, cin=0 -> SUM_o=0x8000_0000, cout_o=0, ovf_o=1.
REQ-024 Backpressure and input isolation:
- Hold ready_i=0 for 10 cycles after valid_o -> outputs stable, ready_o=0 throughout.
- Change A_i/B_i during CALC -> no effect on result.
- Pulse valid_i in DONE -> ignored.
REQ-025 Reset mid-operation: assert rst_i 2 cycles after accepting A=0x1234_5678, B=0x1111_1111 -> all outputs reach reset values immediately. After release, a new request A=5, B=7 yields SUM_o=0x0000_000C.
REQ-026 Random: 10,000 random A/B/cin with random ready_i stalls -> every result matches the reference model, one result per accepted request.
